// File: rtl/serial_pattern_source_if.sv
// Word-in / bit-out handshake bundle for serial_pattern_source.
// master = host and bit consumer side, slave = the pattern source itself.
interface serial_pattern_source_if #(
  parameter int WORD_W = 16
) ();
  logic [WORD_W-1:0] in_word;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;
  logic              bit_last;

  modport master (
    output in_word, in_last, in_valid, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_last
  );

  modport slave (
    input  in_word, in_last, in_valid, bit_ready,
    output in_ready, bit_out, bit_valid, bit_last
  );
endinterface

// File: rtl/serial_pattern_source.sv
// Buffers host words in a small FIFO and streams them MSB-first with bit-level valid/ready.
// Build option STREAM_PRELOAD_EN: reset leaves one frame (1001100110010010, last) queued.
module serial_pattern_source #(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_pattern_source_if.slave  s_if,
  output logic                    busy,
  output logic [7:0]              words_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(WORD_W);

`ifdef STREAM_PRELOAD_EN
  localparam logic [WORD_W:0] PRELOAD_ENTRY = {1'b1, 16'b1001100110010010};
  localparam logic [PW-1:0]   WR_PTR_RST    = PW'(1);
`else
  localparam logic [WORD_W:0] PRELOAD_ENTRY = '0;
  localparam logic [PW-1:0]   WR_PTR_RST    = '0;
`endif

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        ws_q, ws_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [WORD_W:0]   mem_q [FIFO_DEPTH];

  logic [PW-1:0]     count_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              accept_s;
  logic              word_done_s;
  logic [WORD_W:0]   head_s;

  assign count_s     = wr_ptr_q - rd_ptr_q;
  assign full_s      = (count_s == PW'(FIFO_DEPTH));
  assign empty_s     = (wr_ptr_q == rd_ptr_q);
  assign push_s      = s_if.in_valid && !full_s;
  assign accept_s    = (state_q == S_SHIFT) && s_if.bit_ready;
  assign word_done_s = accept_s && (idx_q == IW'(WORD_W - 1));
  assign head_s      = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage and pointers; a full FIFO refuses pushes even while popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      mem_q[0] <= PRELOAD_ENTRY;
      wr_ptr_q <= WR_PTR_RST;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {s_if.in_last, s_if.in_word};
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      ws_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ws_q    <= ws_d;
    end
  end

  // Shifter next state: loads from the FIFO head in IDLE or back-to-back on the last bit.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    idx_d   = idx_q;
    ws_d    = ws_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shreg_d = head_s[WORD_W-1:0];
          last_d  = head_s[WORD_W];
          idx_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (accept_s) begin
          shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
          idx_d   = idx_q + IW'(1);
          if (word_done_s) begin
            if (ws_q != 8'hFF) begin
              ws_d = ws_q + 8'd1;
            end else begin
              ws_d = ws_q;
            end
            if (!empty_s) begin
              pop_s   = 1'b1;
              shreg_d = head_s[WORD_W-1:0];
              last_d  = head_s[WORD_W];
              idx_d   = '0;
              state_d = S_SHIFT;
            end else begin
              last_d  = 1'b0;
              idx_d   = '0;
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        shreg_d = '0;
        last_d  = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign s_if.in_ready  = !full_s;
  assign s_if.bit_out   = shreg_q[WORD_W-1];
  assign s_if.bit_valid = (state_q == S_SHIFT);
  assign s_if.bit_last  = (state_q == S_SHIFT) && last_q && (idx_q == IW'(WORD_W - 1));
  assign busy           = !empty_s || (state_q == S_SHIFT);
  assign words_sent     = ws_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Scoreboard bench for serial_pattern_source: expected bits are queued at each accepted push
// and compared as the DUT hands out bits. Build with STREAM_PRELOAD_EN for the preload frame.
module tb_serial_pattern_source;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] words_sent;

  serial_pattern_source_if #(.WORD_W(16)) bus ();

  serial_pattern_source #(.WORD_W(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_if       (bus),
    .busy       (busy),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] sb [$];          // {end_of_word, last, bit}
  logic [2:0] sb_head;
  logic [7:0] exp_ws = 8'd0;
  logic       mon_en = 1'b0;
  logic [3:0] det = 4'd0;
  int         det_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input logic l);
    int waited = 0;
    bit done = 1'b0;
    bus.in_word  = w;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!done && waited < 300) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        for (int i = 15; i >= 0; i--) begin
          sb.push_back({(i == 0), (l && (i == 0)), w[i]});
        end
      end else begin
        waited++;
      end
    end
    check_eq("push_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic drain(input int max_cyc, output int cyc);
    cyc = 0;
    while (sb.size() != 0 && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("drain_left", sb.size(), 32'd0);
  endtask

  // Bit monitor: compares every offered bit against the scoreboard head, pops on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_eq("words_sent", {24'd0, words_sent}, {24'd0, exp_ws});
        if (sb.size() == 0) begin
          check_eq("idle_valid", {31'd0, bus.bit_valid}, 32'd0);
        end else if (bus.bit_valid) begin
          check_eq("bit_out", {31'd0, bus.bit_out}, {31'd0, sb[0][0]});
          check_eq("bit_last", {31'd0, bus.bit_last}, {31'd0, sb[0][1]});
          if (bus.bit_ready) begin
            sb_head = sb.pop_front();
            if (sb_head[2] && exp_ws != 8'hFF) exp_ws = exp_ws + 8'd1;
            det = {det[2:0], bus.bit_out};
            if (det == 4'b1001) begin
              det_cnt++;
              det = 4'd0;
            end
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int first_rdy;
    logic [15:0] pattern;
    rst_n         = 1'b0;
    bus.in_word   = 16'd0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bit_ready = 1'b0;
    #3;
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
    check_eq("rst_bit_out", {31'd0, bus.bit_out}, 32'd0);
    check_eq("rst_bit_last", {31'd0, bus.bit_last}, 32'd0);
    check_eq("rst_words_sent", {24'd0, words_sent}, 32'd0);
`ifdef STREAM_PRELOAD_EN
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    pattern = 16'b1001100110010010;
    for (int i = 15; i >= 0; i--) sb.push_back({(i == 0), (i == 0), pattern[i]});
    mon_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.bit_ready = 1'b1;
    @(posedge clk);
    #1;
    drain(100, cyc);
    check_eq("pre_cycles", cyc, 32'd16);
    check_eq("pre_busy", {31'd0, busy}, 32'd0);
    check_eq("pre_detect", det_cnt, 32'd3);
`else
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single framed word with the consumer always ready.
    bus.bit_ready = 1'b1;
    push_word(16'hA5C3, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_t0_valid", {31'd0, bus.bit_valid}, 32'd0);
    @(negedge clk);
    check_eq("lat_t1_valid", {31'd0, bus.bit_valid}, 32'd1);
    check_eq("lat_t1_msb", {31'd0, bus.bit_out}, 32'd1);
    @(posedge clk);
    #1;
    drain(100, cyc);
    check_eq("a5c3_busy", {31'd0, busy}, 32'd0);
    check_eq("a5c3_sent", {24'd0, words_sent}, 32'd1);

    // Fill: one word sits in the stalled shifter, four fill the FIFO.
    bus.bit_ready = 1'b0;
    push_word(16'h0001, 1'b0);
    push_word(16'h8000, 1'b0);
    push_word(16'hFFFF, 1'b0);
    push_word(16'h1234, 1'b1);
    push_word(16'h5A5A, 1'b0);
    bus.in_word = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.bit_ready = 1'b1;
    cyc = 0;
    first_rdy = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.in_ready && first_rdy == 0) first_rdy = cyc;
    end
    check_eq("gapless_cycles", cyc, 32'd80);
    check_eq("in_ready_return", first_rdy, 32'd16);
    check_eq("fill_busy", {31'd0, busy}, 32'd0);

    // Every-other-cycle stall on one word.
    bus.bit_ready = 1'b0;
    push_word(16'h9999, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      cyc++;
      bus.bit_ready = (cyc % 2 == 0);
      @(posedge clk);
      #1;
    end
    check_eq("toggle_cycles", cyc, 32'd32);
    bus.bit_ready = 1'b1;

    // Reset after seven bits of a word.
    bus.bit_ready = 1'b0;
    push_word(16'hF0F0, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.bit_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 9 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("mid_left", sb.size(), 32'd9);
    mon_en = 1'b0;
    rst_n = 1'b0;
    bus.bit_ready = 1'b0;
    #1;
    check_eq("mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("mid_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
    check_eq("mid_bit_out", {31'd0, bus.bit_out}, 32'd0);
    check_eq("mid_bit_last", {31'd0, bus.bit_last}, 32'd0);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_words_sent", {24'd0, words_sent}, 32'd0);
    sb.delete();
    exp_ws = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.bit_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_valid", {31'd0, bus.bit_valid}, 32'd0);
      check_eq("post_rst_sent", {24'd0, words_sent}, 32'd0);
    end
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Saturation of the streamed-word counter.
    for (int i = 0; i < 260; i++) begin
      push_word(16'($urandom), 1'b0);
    end
    bus.in_valid = 1'b0;
    drain(5000, cyc);
    @(posedge clk);
    #1;
    check_eq("sat_sent", {24'd0, words_sent}, 32'd255);
    check_eq("sat_busy", {31'd0, busy}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
